lab4_freq_meter: RTL and testbench

LAB4_FREQ_METER -- requirements
Module: lab4_freq_meter

---
 rtl/lab4_freq_meter.sv | 137 +++++++++++++
 tb/tb_lab4_freq_meter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lab4_freq_meter.sv
// Gated frequency meter: counts synchronized rising edges of sig_in over a fixed window of
// GATE_CYCLES f_crys cycles and publishes the saturating count with a one-cycle valid pulse.
module lab4_freq_meter #(
  parameter int unsigned GATE_CYCLES = 100000000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             f_crys,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             valid,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned TimerW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {
    StIdle,
    StGate,
    StLatch
  } state_e;

  state_e             state_q, state_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               flag_q, flag_d;
  logic [CNT_W-1:0]   freq_q, freq_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;
  logic               s1_q, s2_q, s3_q;
  logic               edge_det;

  // Two-flop synchronizer plus one delay flop for rising-edge detection.
  always_ff @(posedge f_crys or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_det = s2_q & ~s3_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    freq_d  = freq_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        cnt_d   = '0;
        flag_d  = 1'b0;
        if (en) begin
          state_d = StGate;
        end
      end
      StGate: begin
        if (!en) begin
          // Abort: discard the window, published results stay untouched.
          state_d = StIdle;
          timer_d = '0;
          cnt_d   = '0;
          flag_d  = 1'b0;
        end else begin
          if (edge_det) begin
            if (cnt_q == CntMax) begin
              flag_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          if (timer_q == TimerLast) begin
            // Results are registered on entry so they are visible alongside valid in LATCH.
            state_d = StLatch;
            timer_d = '0;
            freq_d  = cnt_d;
            ovf_d   = flag_d;
            valid_d = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      StLatch: begin
        // Dead cycle: edges seen here are dropped.
        timer_d = '0;
        cnt_d   = '0;
        flag_d  = 1'b0;
        state_d = en ? StGate : StIdle;
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
        cnt_d   = '0;
        flag_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge f_crys or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      timer_q <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      freq_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      freq_q  <= freq_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign freq  = freq_q;
  assign ovf   = ovf_q;
  assign valid = valid_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_lab4_freq_meter.sv
// Directed bench for lab4_freq_meter with a 100-cycle gate and a 4-bit counter.
module tb_lab4_freq_meter;

  localparam int unsigned GC = 100;
  localparam int unsigned CW = 4;

  localparam int ModeSq  = 0;
  localparam int ModeHi  = 1;
  localparam int ModeLo  = 2;
  localparam int ModeMan = 3;

  logic          f_crys = 1'b0;
  logic          rst;
  logic          en;
  logic          sig_in;
  logic [CW-1:0] freq;
  logic          valid;
  logic          ovf;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int mode = ModeLo;
  int per = 10;
  int ph = 0;

  typedef struct {
    int m;
    int p;
    int ef;
    int eo;
  } vec_t;

  vec_t vecs[11];

  lab4_freq_meter #(
    .GATE_CYCLES(GC),
    .CNT_W      (CW)
  ) dut (
    .f_crys(f_crys),
    .rst   (rst),
    .en    (en),
    .sig_in(sig_in),
    .freq  (freq),
    .valid (valid),
    .ovf   (ovf),
    .busy  (busy)
  );

  initial forever #5 f_crys = ~f_crys;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge f_crys);
    #1;
    case (mode)
      ModeSq: begin
        sig_in = (ph < per / 2);
        ph = (ph + 1 >= per) ? 0 : ph + 1;
      end
      ModeHi: sig_in = 1'b1;
      ModeLo: sig_in = 1'b0;
      default: ;
    endcase
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_pat(input int m, input int p);
    mode = m;
    per = p;
    ph = 0;
  endtask

  task automatic wait_valid(input string name, input int exp_gap, input bit chk_hold,
                            input int hf, input int ho);
    int n = 0;
    bit seen = 1'b0;
    bit hold_bad = 1'b0;
    while (!seen && n < 400) begin
      tick();
      n++;
      if (valid) seen = 1'b1;
      else if (chk_hold && (int'(freq) != hf || int'(ovf) != ho)) hold_bad = 1'b1;
    end
    chk($sformatf("%s_seen", name), int'(seen), 1);
    if (seen) begin
      if (exp_gap > 0) chk($sformatf("%s_gap", name), n, exp_gap);
      chk($sformatf("%s_busy", name), int'(busy), 1);
    end
    if (chk_hold) chk($sformatf("%s_hold", name), int'(hold_bad), 0);
  endtask

  function automatic bit det_at(input int d);
    return (d == 1) || (d == 100) || (d == 202) || (d == 204);
  endfunction

  initial begin
    int pf;
    int po;
    int vcnt;

    vecs[0]  = '{ModeSq, 10, 10, 0};
    vecs[1]  = '{ModeSq, 4, 15, 1};
    vecs[2]  = '{ModeSq, 10, 10, 0};
    vecs[3]  = '{ModeHi, 0, 0, 0};
    vecs[4]  = '{ModeLo, 0, 0, 0};
    vecs[5]  = '{ModeSq, 20, 5, 0};
    vecs[6]  = '{ModeSq, 100, 1, 0};
    vecs[7]  = '{ModeSq, 5, 15, 1};
    vecs[8]  = '{ModeSq, 25, 4, 0};
    vecs[9]  = '{ModeSq, 50, 2, 0};
    vecs[10] = '{ModeSq, 2, 15, 1};

    rst = 1'b1;
    en = 1'b0;
    sig_in = 1'b0;
    repeat (3) tick();
    chk("rst_freq", int'(freq), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_busy", int'(busy), 0);
    en = 1'b1;
    tick();
    chk("rst_en_busy", int'(busy), 0);

    // Release with en high: first valid 101 cycles later, constant-low input reads 0.
    rst = 1'b0;
    wait_valid("first", 101, 1'b1, 0, 0);
    chk("first_freq", int'(freq), 0);
    chk("first_ovf", int'(ovf), 0);

    pf = 0;
    po = 0;
    for (int i = 0; i < 11; i++) begin
      set_pat(vecs[i].m, vecs[i].p);
      wait_valid($sformatf("v%0d_settle", i), 101, 1'b1, pf, po);
      wait_valid($sformatf("v%0d", i), 101, 1'b0, 0, 0);
      chk($sformatf("v%0d_freq", i), int'(freq), vecs[i].ef);
      chk($sformatf("v%0d_ovf", i), int'(ovf), vecs[i].eo);
      pf = vecs[i].ef;
      po = vecs[i].eo;
    end

    // Single-cycle pulses detected in GATE cycles 0 and 99, then in a LATCH cycle.
    en = 1'b0;
    set_pat(ModeMan, 1);
    sig_in = 1'b0;
    repeat (5) tick();
    chk("man_idle_busy", int'(busy), 0);
    vcnt = 0;
    for (int j = -1; j <= 305; j++) begin
      tick();
      if (j == 0) en = 1'b1;
      sig_in = det_at(j + 2);
      if (valid) vcnt++;
      if (j == 101) begin
        chk("edge_first_last_valid", int'(valid), 1);
        chk("edge_first_last_freq", int'(freq), 2);
        chk("edge_first_last_ovf", int'(ovf), 0);
      end
      if (j == 202) begin
        chk("latch_edge_valid", int'(valid), 1);
        chk("latch_edge_freq", int'(freq), 0);
      end
      if (j == 303) begin
        chk("after_latch_valid", int'(valid), 1);
        chk("after_latch_freq", int'(freq), 1);
      end
    end
    chk("man_valid_count", vcnt, 3);

    // Abort at GATE cycle 50 after a freq=10 window.
    set_pat(ModeSq, 10);
    wait_valid("abort_settle", 0, 1'b1, 1, 0);
    wait_valid("abort_pre", 101, 1'b0, 0, 0);
    chk("abort_pre_freq", int'(freq), 10);
    repeat (51) tick();
    chk("abort_busy_before", int'(busy), 1);
    en = 1'b0;
    tick();
    chk("abort_busy_after", int'(busy), 0);
    chk("abort_freq", int'(freq), 10);
    chk("abort_ovf", int'(ovf), 0);
    vcnt = 0;
    repeat (150) begin
      tick();
      if (valid) vcnt++;
    end
    chk("abort_no_valid", vcnt, 0);
    chk("abort_freq_held", int'(freq), 10);

    // Reset at GATE cycle 60.
    en = 1'b1;
    repeat (61) tick();
    chk("rstgate_busy_before", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("rstgate_freq", int'(freq), 0);
    chk("rstgate_valid", int'(valid), 0);
    chk("rstgate_ovf", int'(ovf), 0);
    chk("rstgate_busy", int'(busy), 0);
    tick();
    chk("rstgate_held_busy", int'(busy), 0);
    rst = 1'b0;
    wait_valid("post_rst", 101, 1'b1, 0, 0);
    wait_valid("post_rst2", 101, 1'b0, 0, 0);
    chk("post_rst2_freq", int'(freq), 10);
    chk("post_rst2_ovf", int'(ovf), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
